// File: rtl/fifo_burst_reader.sv
// Read-side controller for a show-ahead FIFO. Drains it into a valid/ready stream as bursts of up to BURST_LEN beats.
// Define FIFO_RD_TIMEOUT_EN to force a short burst after TIMEOUT idle cycles with words stranded below threshold.
module fifo_burst_reader #(
   parameter int DATA_W    = 128,
   parameter int BURST_LEN = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic              fifo_alm_empty,
   input  logic [DATA_W-1:0] fifo_rddata,
   output logic              fifo_rden,
   input  logic              i_flush,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              o_busy,
   output logic [1:0]        o_dbg_state
);

   // Stream handshake: a beat transfers on a clock edge where m_valid & m_ready;
   // while m_valid & !m_ready, m_data/m_last/m_valid hold their values.

   localparam int            CW        = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      LAST = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       pop_cnt_q, pop_cnt_d;
   logic                hold_vld_q, hold_vld_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;
   logic                m_valid_q, m_valid_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;
   logic                m_last_q, m_last_d;
   logic                flush_pend_q, flush_pend_d;

   logic out_free, can_pop, pop, end_cond, move, start, timeout_hit;

   assign out_free = !m_valid_q | m_ready;
   assign can_pop  = (state_q == XFER) & !fifo_empty & (pop_cnt_q < BURST_MAX);
   assign end_cond = hold_vld_q & ((pop_cnt_q == BURST_MAX) | (fifo_empty & (state_q == XFER)));
   // A held word only advances when its slot is refilled or it closes the burst.
   assign move     = hold_vld_q & out_free & (can_pop | end_cond);
   assign pop      = can_pop & (!hold_vld_q | out_free);
   assign start    = (state_q == IDLE) & !fifo_empty & (!fifo_alm_empty | flush_pend_q | timeout_hit);

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int            TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          idle_wait;

   assign idle_wait   = (state_q == IDLE) & !fifo_empty & fifo_alm_empty & !flush_pend_q;
   assign timeout_hit = (idle_cnt_q == TO_MAX);

   always_comb begin
      idle_cnt_d = '0;
      if (idle_wait && !start) begin
         idle_cnt_d = (idle_cnt_q == TO_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) idle_cnt_q <= '0;
      else     idle_cnt_q <= idle_cnt_d;
   end
`else
   // Timeout compiled out: this term is constant zero.
   assign timeout_hit = (TIMEOUT < 0);
`endif

   always_comb begin
      state_d      = state_q;
      pop_cnt_d    = pop_cnt_q;
      hold_vld_d   = hold_vld_q;
      hold_data_d  = hold_data_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_last_d     = m_last_q;
      flush_pend_d = flush_pend_q | i_flush;

      case (state_q)
         IDLE: begin
            // A flush arriving in the entry cycle is served by this burst.
            if (start) begin
               state_d      = XFER;
               pop_cnt_d    = '0;
               flush_pend_d = 1'b0;
            end
         end
         XFER: begin
            if (pop)             pop_cnt_d = pop_cnt_q + 1'b1;
            if (move && end_cond) state_d  = LAST;
         end
         LAST: begin
            if (out_free) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         hold_vld_d  = 1'b1;
         hold_data_d = fifo_rddata;
      end else if (move) begin
         hold_vld_d  = 1'b0;
      end

      if (move) begin
         m_valid_d = 1'b1;
         m_data_d  = hold_data_q;
         m_last_d  = end_cond;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pop_cnt_q    <= '0;
         hold_vld_q   <= 1'b0;
         hold_data_q  <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pop_cnt_q    <= pop_cnt_d;
         hold_vld_q   <= hold_vld_d;
         hold_data_q  <= hold_data_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign fifo_rden   = pop & !rst;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_last      = m_last_q;
   assign o_busy      = (state_q != IDLE) | hold_vld_q | m_valid_q;
   assign o_dbg_state = state_q;

endmodule
